// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and default widths for the register-file write arbiter.
// Imported by the interface, the round-robin picker and the top level.
package regfile_write_arbiter_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 2;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        CLR = 1'b1
    } arbState_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request/grant and register-file write bus between two requesters and the arbiter.
// The arbiter sits on the slave modport; the requester side uses master.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;
    logic              clr_req;
    logic              gnt0;
    logic              gnt1;
    logic              busy;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteR;
    logic [DATA_W-1:0] WriteD;

    modport master (
        output req0, addr0, data0, req1, addr1, data1, clr_req,
        input  gnt0, gnt1, busy, RegWrite, WriteR, WriteD
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1, clr_req,
        output gnt0, gnt1, busy, RegWrite, WriteR, WriteD
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: the prioritised requester wins a tie, otherwise
// whichever single requester is eligible wins.
module rr_arbiter2 (
    input  logic eligible0,
    input  logic eligible1,
    input  logic prio,
    output logic winner,
    output logic valid
);

    // Winner selection from eligibility and the priority pointer
    always_comb begin
        valid = eligible0 | eligible1;
        if (eligible0 && eligible1) begin
            winner = prio;
        end else if (eligible1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two register-file write requesters and runs a zero-fill clear
// sequence over every register; all outputs are registered.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input logic                    clk,
    input logic                    Reset,
    regfile_write_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    arbState_e         state_r,    stateNext_s;
    logic [ADDR_W-1:0] cnt_r,      cntNext_s;
    logic              prio_r,     prioNext_s;
    logic              gnt0_r,     gnt0Next_s;
    logic              gnt1_r,     gnt1Next_s;
    logic              busy_r,     busyNext_s;
    logic              regWrite_r, regWriteNext_s;
    logic [ADDR_W-1:0] writeR_r,   writeRNext_s;
    logic [DATA_W-1:0] writeD_r,   writeDNext_s;

    logic eligible0_s;
    logic eligible1_s;
    logic winner_s;
    logic valid_s;

    // A request still held during its own grant cycle must not win again
    assign eligible0_s = bus.req0 & ~gnt0_r;
    assign eligible1_s = bus.req1 & ~gnt1_r;

    rr_arbiter2 u_rrArbiter (
        .eligible0 (eligible0_s),
        .eligible1 (eligible1_s),
        .prio      (prio_r),
        .winner    (winner_s),
        .valid     (valid_s)
    );

    // Next-state and next-output decode for the RUN/CLR controller
    always_comb begin
        stateNext_s    = state_r;
        cntNext_s      = cnt_r;
        prioNext_s     = prio_r;
        gnt0Next_s     = 1'b0;
        gnt1Next_s     = 1'b0;
        busyNext_s     = 1'b0;
        regWriteNext_s = 1'b0;
        writeRNext_s   = writeR_r;
        writeDNext_s   = writeD_r;
        case (state_r)
            RUN: begin
                if (bus.clr_req) begin
                    stateNext_s    = CLR;
                    cntNext_s      = {ADDR_W{1'b0}};
                    busyNext_s     = 1'b1;
                    regWriteNext_s = 1'b1;
                    writeRNext_s   = {ADDR_W{1'b0}};
                    writeDNext_s   = {DATA_W{1'b0}};
                end else if (valid_s) begin
                    regWriteNext_s = 1'b1;
                    prioNext_s     = ~winner_s;
                    if (winner_s) begin
                        gnt1Next_s   = 1'b1;
                        writeRNext_s = bus.addr1;
                        writeDNext_s = bus.data1;
                    end else begin
                        gnt0Next_s   = 1'b1;
                        writeRNext_s = bus.addr0;
                        writeDNext_s = bus.data0;
                    end
                end else begin
                    regWriteNext_s = 1'b0;
                end
            end
            CLR: begin
                // cnt_r is the index being written this cycle; clr_req is ignored here
                if (cnt_r == LAST_IDX) begin
                    stateNext_s = RUN;
                    cntNext_s   = {ADDR_W{1'b0}};
                end else begin
                    cntNext_s      = cnt_r + CNT_ONE;
                    busyNext_s     = 1'b1;
                    regWriteNext_s = 1'b1;
                    writeRNext_s   = cnt_r + CNT_ONE;
                    writeDNext_s   = {DATA_W{1'b0}};
                end
            end
            default: begin
                stateNext_s = RUN;
                cntNext_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, pointer, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r    <= RUN;
            cnt_r      <= {ADDR_W{1'b0}};
            prio_r     <= 1'b0;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            busy_r     <= 1'b0;
            regWrite_r <= 1'b0;
            writeR_r   <= {ADDR_W{1'b0}};
            writeD_r   <= {DATA_W{1'b0}};
        end else begin
            state_r    <= stateNext_s;
            cnt_r      <= cntNext_s;
            prio_r     <= prioNext_s;
            gnt0_r     <= gnt0Next_s;
            gnt1_r     <= gnt1Next_s;
            busy_r     <= busyNext_s;
            regWrite_r <= regWriteNext_s;
            writeR_r   <= writeRNext_s;
            writeD_r   <= writeDNext_s;
        end
    end

    assign bus.gnt0     = gnt0_r;
    assign bus.gnt1     = gnt1_r;
    assign bus.busy     = busy_r;
    assign bus.RegWrite = regWrite_r;
    assign bus.WriteR   = writeR_r;
    assign bus.WriteD   = writeD_r;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: register data width.
REQ-002 Parameter ADDR_W, default 2: register index width; register count NUM_REGS = 2**ADDR_W (default 4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset; synchronous and active-high.
REQ-005 req0  input  1  write request, requester 0; held until gnt0 seen.
REQ-006 addr0  input  ADDR_W  target register, requester 0; stable while req0 high.
REQ-007 data0  input  DATA_W  write data, requester 0; stable while req0 high.
REQ-008 req1 / addr1 / data1  input  1 / ADDR_W / DATA_W  same roles for requester 1.
REQ-009 clr_req  input  1  one-cycle pulse: zero every register.
REQ-010 gnt0, gnt1  output  1  registered one-cycle grant pulses.
REQ-011 busy  output  1  high while clear sequence runs.
REQ-012 RegWrite  output  1  register-file write enable (registered).
REQ-013 WriteR  output  ADDR_W  register-file write index (registered).
REQ-014 WriteD  output  DATA_W  register-file write data (registered).

Function
REQ-015 States: RUN, CLR; 2-bit clear counter cnt; 1-bit round-robin pointer prio (requester with priority).
REQ-016 Arbitration occurs only in RUN cycles with clr_req=0; eligible_i = req_i AND NOT gnt_i (no re-grant of a request still held during its grant cycle).
REQ-017 One eligible requester in cycle N: next cycle gnt_i=1, RegWrite=1, WriteR=addr_i, WriteD=data_i (latency 1).
REQ-018 Both eligible: requester prio wins; prio then flips to loser; single-requester grant also sets prio to the other requester.
REQ-019 No eligible requester: next cycle RegWrite=0, gnt0=gnt1=0; WriteR/WriteD hold last values.
REQ-020 At most one of gnt0, gnt1 high in any cycle; RegWrite=1 exactly when a grant or clear write is issued.
REQ-021 clr_req=1 in RUN cycle N: state->CLR, cnt=0; no grant issued from cycle N, even if requests present.
REQ-022 CLR cycles N+1..N+NUM_REGS: busy=1, RegWrite=1, WriteR=cnt, WriteD=0, cnt increments; after cnt=NUM_REGS-1 state->RUN.
REQ-023 First RUN cycle after clear (busy=0) arbitrates; requests pending during CLR are retained, not lost, granted per REQ-017/018.
REQ-024 clr_req during CLR ignored (no restart, no extension).
REQ-025 gnt0, gnt1 never asserted while busy=1.
REQ-026 Arbitration never selects on addr values; same-address writes from both requesters serialise, later grant overwrites.

Reset
REQ-027 Reset=1 at rising edge: state=RUN, cnt=0, prio=0, gnt0=gnt1=0, busy=0, RegWrite=0, WriteR=0, WriteD=0; overrides all other inputs.
REQ-028 Reset mid-clear aborts sequence; remaining registers not cleared; no grant in reset cycle; arbitration resumes first cycle after Reset falls.

Structure
REQ-029 Shared package holds state encoding (RUN, CLR) and default width constants DATA_W=8, ADDR_W=2.
REQ-030 One sub-module rr_arbiter2: 2-way round-robin pick (eligible0/1, prio in; winner, valid out), combinational; FSM, counter, output registers stay in regfile_write_arbiter.

Verification
REQ-031 Reset 2 cycles, req0 addr0=1 data0=8'h2A one cycle -> next cycle gnt0=1, RegWrite=1, WriteR=1, WriteD=8'h2A; following cycle RegWrite=0.
REQ-032 req0 (addr 0, 8'h11) and req1 (addr 3, 8'h33) both held after reset -> grants gnt0 then gnt1 on consecutive cycles; writes reg0=8'h11, reg3=8'h33; no double grant.
REQ-033 Both requesters held continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; RegWrite=1 each cycle.
REQ-034 clr_req pulse with req1 held (addr 2, 8'h55) same cycle -> 4 cycles busy=1, WriteR=0,1,2,3, WriteD=0; then one cycle busy=0 arbitration, gnt1 next cycle with WriteR=2, WriteD=8'h55.
REQ-035 Reset asserted on second CLR cycle -> next cycle busy=0, RegWrite=0, all outputs at reset values; second clr_req during CLR causes no extra clear cycles.
REQ-036 Bench instantiates register file with outputs: after REQ-032 then REQ-034, reading indices 0..3 returns 0,0,8'h55,0.
